// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: privilege encoding, SP mux selects, PSR bit
// positions, reset values of the saved stack pointers and a PSR packer.
package lc3_pkg;

    // Privilege level as stored in PSR[15]
    typedef enum logic {
        PRIV_SUPERVISOR = 1'b0,
        PRIV_USER       = 1'b1
    } priv_e;

    // SP mux selects feeding the register-file input mux
    localparam logic [1:0] SP_INC = 2'd0;
    localparam logic [1:0] SP_DEC = 2'd1;
    localparam logic [1:0] SP_SSP = 2'd2;
    localparam logic [1:0] SP_USP = 2'd3;

    // PSR field positions
    localparam int PSR_PRIV    = 15;
    localparam int PSR_PRIO_HI = 10;
    localparam int PSR_PRIO_LO = 8;
    localparam int PSR_NZP_HI  = 2;
    localparam int PSR_NZP_LO  = 0;

    // Power-on contents of the saved stack pointers
    localparam logic [15:0] SAVED_SSP_RST = 16'h3000;
    localparam logic [15:0] SAVED_USP_RST = 16'hFE00;

    // Assemble the bus-visible PSR word; unused bits read as zero
    function automatic logic [15:0] psr_word(input logic       priv,
                                             input logic [2:0] prio,
                                             input logic [2:0] nzp);
        logic [15:0] w;
        w = 16'h0000;
        w[PSR_PRIV] = priv;
        w[PSR_PRIO_HI:PSR_PRIO_LO] = prio;
        w[PSR_NZP_HI:PSR_NZP_LO] = nzp;
        return w;
    endfunction

endpackage

// File: rtl/lc3_ben_logic.sv
// Branch-enable reduction: any IR[11:9] mask bit matching a set condition
// code enables the branch. Kept separate so a branch predictor can reuse it.
module lc3_ben_logic (
    input  logic [2:0] nzp,
    input  logic [2:0] ir_mask,
    output logic       ben
);

    // Mask the condition codes with n,z,p from the IR and OR-reduce
    always_comb begin
        ben = |(ir_mask & nzp);
    end

endmodule

// File: rtl/lc3_psr_unit.sv
// LC-3 processor-status unit: registered BEN, privilege FSM, priority,
// interrupt and access-violation flags, PSR assembly and the SP mux.
// Optional feature macro: LC3_PSR_SAVED_SP_EN adds the Saved.SSP/Saved.USP
// registers and SP mux selects 2/3; without it those selects pass i_SR1.
module lc3_psr_unit
    import lc3_pkg::*;
#(
    parameter logic [15:0] USER_SPACE_LO = 16'h3000,
    parameter logic [15:0] USER_SPACE_HI = 16'hFE00
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic [2:0]  i_NZP,
    input  logic [2:0]  i_IR_11_9,
    input  logic        i_LD_BEN,
    input  logic [15:0] i_Bus,
    input  logic        i_LD_PSR,
    input  logic        i_LD_Priv,
    input  logic        i_Set_Priv,
    input  logic        i_LD_Priority,
    input  logic        i_INT_Req,
    input  logic [2:0]  i_INT_Priority,
    input  logic [15:0] i_MAR,
    input  logic        i_LD_ACV,
    input  logic [15:0] i_SR1,
    input  logic        i_LD_Saved_SSP,
    input  logic        i_LD_Saved_USP,
    input  logic [1:0]  i_SPMux_Sel,
    output logic        o_BEN,
    output logic        o_Priv,
    output logic [2:0]  o_Priority,
    output logic [15:0] o_PSR,
    output logic        o_INT,
    output logic        o_ACV,
    output logic [15:0] o_SP
);

    // Address lies outside the region user mode may touch
    function automatic logic outside_user_space(input logic [15:0] addr);
        return (addr < USER_SPACE_LO) || (addr >= USER_SPACE_HI);
    endfunction

    // Stack-pointer step helpers; both wrap modulo 2^16
    function automatic logic [15:0] sp_inc(input logic [15:0] sp);
        return sp + 16'd1;
    endfunction

    function automatic logic [15:0] sp_dec(input logic [15:0] sp);
        return sp - 16'd1;
    endfunction

    priv_e       priv_state;
    priv_e       priv_next;
    logic [2:0]  priority_q;
    logic [2:0]  priority_next;
    logic        ben_q;
    logic        ben_comb;
    logic        int_q;
    logic        acv_q;

    // Only PSR[15] and PSR[10:8] are restored from the bus
    logic        unused_bus_bits;
    assign unused_bus_bits = ^{i_Bus[14:11], i_Bus[7:0]};

    lc3_ben_logic u_ben_logic (
        .nzp     (i_NZP),
        .ir_mask (i_IR_11_9),
        .ben     (ben_comb)
    );

    // BEN register: loads the reduced mask on LD_BEN, otherwise holds
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            ben_q <= 1'b0;
        end else if (i_LD_BEN) begin
            ben_q <= ben_comb;
        end
    end

    // Privilege FSM state register
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            priv_state <= PRIV_SUPERVISOR;
        end else begin
            priv_state <= priv_next;
        end
    end

    // Privilege next state: PSR restore overrides an explicit privilege load
    always_comb begin
        priv_next = priv_state;
        if (i_LD_PSR) begin
            priv_next = priv_e'(i_Bus[PSR_PRIV]);
        end else if (i_LD_Priv) begin
            priv_next = priv_e'(i_Set_Priv);
        end
    end

    // Priority next value: PSR restore overrides an interrupt-priority load
    always_comb begin
        priority_next = priority_q;
        if (i_LD_PSR) begin
            priority_next = i_Bus[PSR_PRIO_HI:PSR_PRIO_LO];
        end else if (i_LD_Priority) begin
            priority_next = i_INT_Priority;
        end
    end

    // Priority register
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            priority_q <= 3'b000;
        end else begin
            priority_q <= priority_next;
        end
    end

    // Interrupt flag re-evaluated every cycle against the pre-update priority
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            int_q <= 1'b0;
        end else begin
            int_q <= i_INT_Req && (i_INT_Priority > priority_q);
        end
    end

    // Access violation: only user mode is restricted, latched on LD_ACV
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            acv_q <= 1'b0;
        end else if (i_LD_ACV) begin
            acv_q <= (priv_state == PRIV_USER) && outside_user_space(i_MAR);
        end
    end

`ifdef LC3_PSR_SAVED_SP_EN
    logic [15:0] saved_ssp_q;
    logic [15:0] saved_usp_q;

    // Saved stack pointers load independently from SR1
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            saved_ssp_q <= SAVED_SSP_RST;
            saved_usp_q <= SAVED_USP_RST;
        end else begin
            if (i_LD_Saved_SSP) begin
                saved_ssp_q <= i_SR1;
            end
            if (i_LD_Saved_USP) begin
                saved_usp_q <= i_SR1;
            end
        end
    end

    // SP mux including the saved stack pointers
    always_comb begin
        o_SP = i_SR1;
        case (i_SPMux_Sel)
            SP_INC:  o_SP = sp_inc(i_SR1);
            SP_DEC:  o_SP = sp_dec(i_SR1);
            SP_SSP:  o_SP = saved_ssp_q;
            SP_USP:  o_SP = saved_usp_q;
            default: o_SP = i_SR1;
        endcase
    end
`else
    // Saved-SP loads have no destination in this build
    logic unused_saved_ld;
    assign unused_saved_ld = i_LD_Saved_SSP ^ i_LD_Saved_USP;

    // SP mux without saved registers: selects 2 and 3 pass SR1 through
    always_comb begin
        o_SP = i_SR1;
        case (i_SPMux_Sel)
            SP_INC:  o_SP = sp_inc(i_SR1);
            SP_DEC:  o_SP = sp_dec(i_SR1);
            default: o_SP = i_SR1;
        endcase
    end
`endif

    assign o_BEN      = ben_q;
    assign o_Priv     = priv_state;
    assign o_Priority = priority_q;
    assign o_INT      = int_q;
    assign o_ACV      = acv_q;
    assign o_PSR      = psr_word(priv_state, priority_q, i_NZP);

endmodule

// File: tb/tb_lc3_psr_unit.sv
// Self-checking bench for lc3_psr_unit: directed steps from the test plan
// followed by random cycles, all compared against a behavioural model.
module tb_lc3_psr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  nzp;
    logic [2:0]  ir;
    logic        ld_ben;
    logic [15:0] bus;
    logic        ld_psr;
    logic        ld_priv;
    logic        set_priv;
    logic        ld_priority;
    logic        int_req;
    logic [2:0]  int_prio;
    logic [15:0] mar;
    logic        ld_acv;
    logic [15:0] sr1;
    logic        ld_ssp;
    logic        ld_usp;
    logic [1:0]  sp_sel;
    logic        ben;
    logic        priv;
    logic [2:0]  prio;
    logic [15:0] psr;
    logic        intf;
    logic        acv;
    logic [15:0] sp;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_ben, m_priv, m_prio, m_int, m_acv, m_ssp, m_usp;

    always #5 clk = ~clk;

    lc3_psr_unit dut (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_NZP          (nzp),
        .i_IR_11_9      (ir),
        .i_LD_BEN       (ld_ben),
        .i_Bus          (bus),
        .i_LD_PSR       (ld_psr),
        .i_LD_Priv      (ld_priv),
        .i_Set_Priv     (set_priv),
        .i_LD_Priority  (ld_priority),
        .i_INT_Req      (int_req),
        .i_INT_Priority (int_prio),
        .i_MAR          (mar),
        .i_LD_ACV       (ld_acv),
        .i_SR1          (sr1),
        .i_LD_Saved_SSP (ld_ssp),
        .i_LD_Saved_USP (ld_usp),
        .i_SPMux_Sel    (sp_sel),
        .o_BEN          (ben),
        .o_Priv         (priv),
        .o_Priority     (prio),
        .o_PSR          (psr),
        .o_INT          (intf),
        .o_ACV          (acv),
        .o_SP           (sp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, computed from the current inputs
    function automatic void model_edge();
        int a, nb;
        if (!rst_n) begin
            m_ben = 0; m_priv = 0; m_prio = 0; m_int = 0; m_acv = 0;
            m_ssp = 'h3000; m_usp = 'hFE00;
            return;
        end
        if (ld_ben) begin
            nb = 0;
            if (ir[2] && nzp[2]) nb = 1;
            if (ir[1] && nzp[1]) nb = 1;
            if (ir[0] && nzp[0]) nb = 1;
            m_ben = nb;
        end
        m_int = (int_req && (int'(int_prio) > m_prio)) ? 1 : 0;
        if (ld_acv) begin
            a = int'(mar);
            m_acv = (m_priv == 1 && (a < 'h3000 || a >= 'hFE00)) ? 1 : 0;
        end
        if (ld_psr) begin
            m_priv = int'(bus) / 32768;
            m_prio = (int'(bus) / 256) % 8;
        end else begin
            if (ld_priv) m_priv = int'(set_priv);
            if (ld_priority) m_prio = int'(int_prio);
        end
        if (ld_ssp) m_ssp = int'(sr1);
        if (ld_usp) m_usp = int'(sr1);
    endfunction

    function automatic int model_sp();
        int s;
        s = int'(sr1);
        case (sp_sel)
            2'd0: return (s + 1) % 65536;
            2'd1: return (s + 65535) % 65536;
`ifdef LC3_PSR_SAVED_SP_EN
            2'd2: return m_ssp;
            default: return m_usp;
`else
            default: return s;
`endif
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".ben"},  32'(ben),  m_ben);
        check({tag, ".priv"}, 32'(priv), m_priv);
        check({tag, ".prio"}, 32'(prio), m_prio);
        check({tag, ".int"},  32'(intf), m_int);
        check({tag, ".acv"},  32'(acv),  m_acv);
        check({tag, ".psr"},  32'(psr),  m_priv * 32768 + m_prio * 256 + int'(nzp));
        check({tag, ".sp"},   32'(sp),   model_sp());
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_loads();
        ld_ben = 0; ld_psr = 0; ld_priv = 0; ld_priority = 0;
        ld_acv = 0; ld_ssp = 0; ld_usp = 0; int_req = 0;
    endtask

    initial begin
        m_ben = 0; m_priv = 0; m_prio = 0; m_int = 0; m_acv = 0;
        m_ssp = 'h3000; m_usp = 'hFE00;

        // Reset with every load asserted
        rst_n = 0; nzp = 3'b101; ir = 3'b111; bus = 16'hFFFF; set_priv = 1;
        int_prio = 3'd7; mar = 16'h0000; sr1 = 16'h1234; sp_sel = 2'd2;
        ld_ben = 1; ld_psr = 1; ld_priv = 1; ld_priority = 1; int_req = 1;
        ld_acv = 1; ld_ssp = 1; ld_usp = 1;
        tick("reset");
        check("rst_ben", 32'(ben), 0);
        check("rst_priv", 32'(priv), 0);
        check("rst_prio", 32'(prio), 0);
        check("rst_int", 32'(intf), 0);
        check("rst_acv", 32'(acv), 0);
        check("rst_psr", 32'(psr), 32'h0005);
        rst_n = 1;
        clear_loads();
        tick("idle");

        // BEN mask and reduce, then hold
        nzp = 3'b010; ir = 3'b101; ld_ben = 1;
        tick("ben101");
        check("ben_mask101", 32'(ben), 0);
        ir = 3'b011;
        tick("ben011");
        check("ben_mask011", 32'(ben), 1);
        ld_ben = 0; nzp = 3'b100;
        tick("ben_hold1");
        nzp = 3'b001; ir = 3'b100;
        tick("ben_hold2");
        check("ben_hold", 32'(ben), 1);

        // PSR load beats privilege and priority loads
        bus = 16'h8300; ld_psr = 1; ld_priv = 1; set_priv = 0;
        ld_priority = 1; int_prio = 3'd7; nzp = 3'b010;
        tick("prec");
        clear_loads();
        check("prec_priv", 32'(priv), 1);
        check("prec_prio", 32'(prio), 3);
        check("prec_psr", 32'(psr), 32'h8302);

        // Interrupt: strict priority comparison, not sticky
        ld_priority = 1; int_prio = 3'd4;
        tick("int_setprio");
        ld_priority = 0; int_req = 1; int_prio = 3'd4;
        tick("int_eq");
        check("int_equal", 32'(intf), 0);
        int_prio = 3'd5;
        tick("int_gt");
        check("int_higher", 32'(intf), 1);
        int_req = 0;
        tick("int_drop");
        check("int_dropped", 32'(intf), 0);

        // Access violation in user mode, then supervisor
        ld_priv = 1; set_priv = 1;
        tick("to_user");
        ld_priv = 0; ld_acv = 1; mar = 16'h2FFF;
        tick("acv_2fff");
        check("acv_below", 32'(acv), 1);
        mar = 16'h3000;
        tick("acv_3000");
        check("acv_lo_edge", 32'(acv), 0);
        mar = 16'hFE00;
        tick("acv_fe00");
        check("acv_hi_edge", 32'(acv), 1);
        ld_acv = 0; ld_priv = 1; set_priv = 0;
        tick("to_super");
        ld_priv = 0; ld_acv = 1; mar = 16'hFE00;
        tick("acv_super");
        check("acv_supervisor", 32'(acv), 0);
        ld_acv = 0;

        // SP mux wrap-around and saved USP
        sp_sel = 2'd0; sr1 = 16'hFFFF; #1;
        check("sp_inc_wrap", 32'(sp), 32'h0000);
        sp_sel = 2'd1; sr1 = 16'h0000; #1;
        check("sp_dec_wrap", 32'(sp), 32'hFFFF);
        ld_usp = 1; sr1 = 16'hBEEF;
        tick("usp_load");
        ld_usp = 0; sp_sel = 2'd3; sr1 = 16'h1234; #1;
`ifdef LC3_PSR_SAVED_SP_EN
        check("sp_usp", 32'(sp), 32'hBEEF);
`else
        check("sp_usp_passthru", 32'(sp), 32'h1234);
`endif
        sp_sel = 2'd2; #1;
        check("sp_ssp", 32'(sp), 32'(model_sp()));

        // Random cycles against the model
        for (int i = 0; i < 400; i++) begin
            rst_n       = ($urandom_range(0, 31) != 0);
            nzp         = 3'($urandom_range(0, 7));
            ir          = 3'($urandom_range(0, 7));
            bus         = 16'($urandom_range(0, 65535));
            set_priv    = 1'($urandom_range(0, 1));
            int_prio    = 3'($urandom_range(0, 7));
            mar         = 16'($urandom_range(0, 65535));
            sr1         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
            sp_sel      = 2'($urandom_range(0, 3));
            ld_ben      = ($urandom_range(0, 2) == 0);
            ld_psr      = ($urandom_range(0, 5) == 0);
            ld_priv     = ($urandom_range(0, 3) == 0);
            ld_priority = ($urandom_range(0, 3) == 0);
            int_req     = ($urandom_range(0, 1) == 0);
            ld_acv      = ($urandom_range(0, 2) == 0);
            ld_ssp      = ($urandom_range(0, 4) == 0);
            ld_usp      = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_psr_unit.md
# lc3_psr_unit

Processor-status and branch-condition stage that sits directly downstream of `lc3_nzp`. It consumes the registered condition codes and the IR branch field to produce the registered BEN bit for the microsequencer. It also holds the rest of the PSR (privilege, priority), assembles the full 16-bit PSR word for the bus, and raises the interrupt (INT) and access-control-violation (ACV) flags. It also owns the Saved.SSP/Saved.USP stack-pointer registers and the SP mux used on TRAP, interrupt and RTI stack switches.

## Interface
Parameters:
- `USER_SPACE_LO`, 16'h3000, lowest address user mode may access
- `USER_SPACE_HI`, 16'hFE00, first address (device/IO space) user mode may not access

Ports:
- `i_CLK`  in  1  clock; all state updates on posedge
- `i_RST_N`  in  1  reset; synchronous, active-low
- `i_NZP`  in  3  condition codes from `lc3_nzp` (N=2, Z=1, P=0)
- `i_IR_11_9`  in  3  branch mask n,z,p from IR
- `i_LD_BEN`  in  1  load BEN register
- `i_Bus`  in  16  data bus (PSR restore on RTI)
- `i_LD_PSR`  in  1  load priv/priority from `i_Bus[15]` and `i_Bus[10:8]`
- `i_LD_Priv`  in  1  load privilege from `i_Set_Priv`
- `i_Set_Priv`  in  1  0 = supervisor, 1 = user
- `i_LD_Priority`  in  1  load priority from `i_INT_Priority`
- `i_INT_Req`  in  1  external interrupt request
- `i_INT_Priority`  in  3  priority of the requesting device
- `i_MAR`  in  16  current memory address
- `i_LD_ACV`  in  1  evaluate and latch the ACV flag
- `i_SR1`  in  16  SR1 register-file output (R6)
- `i_LD_Saved_SSP`  in  1  Saved.SSP <= `i_SR1`
- `i_LD_Saved_USP`  in  1  Saved.USP <= `i_SR1`
- `i_SPMux_Sel`  in  2  SP mux select
- `o_BEN`  out  1  registered branch enable
- `o_Priv`  out  1  current privilege (PSR[15])
- `o_Priority`  out  3  current priority (PSR[10:8])
- `o_PSR`  out  16  {Priv, 4'b0, Priority, 5'b0, `i_NZP`}
- `o_INT`  out  1  registered interrupt-pending flag
- `o_ACV`  out  1  registered access-violation flag
- `o_SP`  out  16  SP mux output, to the register-file input mux

## Operation
- BEN: on `i_LD_BEN`, BEN <= (IR[11]&N) | (IR[10]&Z) | (IR[9]&P); otherwise it holds.
- Privilege FSM with two states:
  - SUPERVISOR (Priv = 0) and USER (Priv = 1).
  - `i_LD_PSR` moves to the state given by `i_Bus[15]`.
  - Else `i_LD_Priv` moves to the state given by `i_Set_Priv`.
  - Else the state holds.
- Priority:
  - `i_LD_PSR` loads `i_Bus[10:8]`.
  - Else `i_LD_Priority` loads `i_INT_Priority`.
  - Else it holds.
- Precedence: `i_LD_PSR` overrides both `i_LD_Priv` and `i_LD_Priority` in the same cycle.
- INT: every cycle, INT <= `i_INT_Req` && (`i_INT_Priority` > Priority). The comparison is strict and unsigned 3-bit. It uses the Priority value before any same-cycle update.
- ACV: on `i_LD_ACV`, ACV <= Priv && (`i_MAR` < USER_SPACE_LO || `i_MAR` >= USER_SPACE_HI); otherwise it holds.
- SP mux (combinational, 16-bit, wraps modulo 2^16):
  - 0 = `i_SR1` + 1
  - 1 = `i_SR1` − 1
  - 2 = Saved.SSP
  - 3 = Saved.USP
- Saved.SSP and Saved.USP load independently and may load in the same cycle.
- `o_PSR` is combinational from the registered fields and `i_NZP`; unused bits read 0.

## Timing
- Reset values: BEN = 0, Priv = 0 (SUPERVISOR), Priority = 3'b000, INT = 0, ACV = 0, Saved.SSP = 16'h3000, Saved.USP = 16'hFE00.
- Reset while any load is asserted: reset wins and all loads are ignored.
- `o_PSR` at reset = 16'h0000 | `i_NZP`.
- Latency: BEN, Priv, Priority, INT, ACV and the saved SPs are visible one cycle after the load/request edge.
- `o_SP` and `o_PSR` have zero-cycle combinational latency.
- BEN samples `i_NZP` as it is before the edge. A same-edge NZP update in `lc3_nzp` is not seen until the next BEN load.
- INT is not sticky: it deasserts one cycle after `i_INT_Req` drops or after Priority rises to at least `i_INT_Priority`.
- Wrap-around: SR1 = 16'hFFFF with sel 0 gives 16'h0000; SR1 = 16'h0000 with sel 1 gives 16'hFFFF.

## Configuration
- `LC3_PSR_SAVED_SP_EN`
  - Defined: Saved.SSP/Saved.USP registers and SP mux selects 2 and 3 exist as above.
  - Undefined: the registers are removed, `i_LD_Saved_*` are ignored, and selects 2 and 3 return `i_SR1` unchanged. BEN, PSR, INT and ACV are unaffected.

## Structure
- Shared package `lc3_pkg`:
  - privilege enum (PRIV_SUPERVISOR = 0, PRIV_USER = 1)
  - SPMux select constants (SP_INC, SP_DEC, SP_SSP, SP_USP)
  - PSR bit positions (PSR_PRIV = 15, PSR_PRIO = 10:8, PSR_NZP = 2:0)
- One natural sub-module: `lc3_ben_logic`, the combinational mask-and-reduce of IR[11:9] against NZP. It is reusable by a future branch predictor.

## Test plan
- Reset with all loads high → after the edge, BEN = 0, Priv = 0, Priority = 0, INT = 0, ACV = 0, `o_PSR` = 16'h0000 | `i_NZP`.
- BEN: NZP = 3'b010 and IR[11:9] = 3'b101 with LD_BEN → BEN = 0; IR[11:9] = 3'b011 → BEN = 1; with LD_BEN low, BEN holds across NZP changes.
- Precedence: LD_PSR with Bus = 16'h8300 together with LD_Priv (Set_Priv = 0) and LD_Priority (INT_Priority = 7) → Priv = 1, Priority = 3, `o_PSR` = 16'h8300 | NZP.
- INT: Priority = 4 with INT_Req and INT_Priority = 4 → INT = 0; INT_Priority = 5 → INT = 1 the next cycle; drop INT_Req → INT = 0 one cycle later.
- ACV in user mode:
  - MAR = 16'h2FFF with LD_ACV → ACV = 1.
  - MAR = 16'h3000 → ACV = 0.
  - MAR = 16'hFE00 → ACV = 1.
  - Supervisor mode with MAR = 16'hFE00 → ACV = 0.
- SP:
  - SR1 = 16'hFFFF with sel 0 → 16'h0000; SR1 = 16'h0000 with sel 1 → 16'hFFFF.
  - Load Saved.USP = 16'hBEEF → sel 3 gives 16'hBEEF.
  - With `LC3_PSR_SAVED_SP_EN` undefined, sel 3 gives `i_SR1`.
